vga_mode_sel: RTL
=================

// Module: vga_mode_sel
// PURPOSE
//  Upstream control stage for the dual-resolution VGA output mux: replaces the raw
//  board switch as the mux select. Synchronises and debounces the switch, then commits
//  a mode change only at the leading edge of the active mode's vertical sync. It blanks
//  RGB for a programmable number of frames of the new mode so the monitor relocks cleanly.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive clk cycles sw must disagree with mode (10 ms @100 MHz)
//  FRAME_TIMEOUT    2_000_000  max clk cycles to wait for a VS leading edge before forcing progress
//  BLANK_FRAMES     2          frames of new mode held blanked after a switch; legal range >= 1
//  VS_POL           0          VS sync polarity for both inputs: 0 = active-low pulse, 1 = active-high
// PORTS
//  clk         in   1  system clock, 100 MHz; the only clock
//  rst         in   1  reset, asynchronous, active-high
//  sw          in   1  raw mode switch (asynchronous, bouncy); 0 = 640x480, 1 = 800x600
//  vs_640_480  in   1  VS output of 640x480 timing controller
//  vs_800_600  in   1  VS output of 800x600 timing controller
//  mode        out  1  registered mux select; 0 = 640x480, 1 = 800x600
//  blank       out  1  1 = downstream forces RGB to 0 (sync signals still pass)
//  busy        out  1  1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: mode=0, blank=0, busy=0, state IDLE, all counters 0, sync flops 0.
//  sw, vs_640_480 and vs_800_600 each pass through a 2-FF synchroniser (sw_s, vs*_s).
//  VS leading edge = sync-asserted transition of the synchronised signal per VS_POL, 1-cycle pulse.
//  vs_cur = edge of the mode currently selected by mode.
//  FSM:
//   IDLE:       sw_s != mode -> DEBOUNCE, db_cnt=0.
//   DEBOUNCE:   sw_s == mode -> IDLE (bounce rejected). Otherwise db_cnt++.
//               When db_cnt == DEBOUNCE_CYCLES-1 -> WAIT_FRAME, to_cnt=0.
//   WAIT_FRAME: sw_s == mode -> IDLE (abort, no switch). On vs_cur, or on
//               to_cnt == FRAME_TIMEOUT-1: mode <= ~mode, blank <= 1, fr_cnt=0, to_cnt=0 -> BLANK.
//               Abort takes priority over a same-cycle edge or timeout.
//   BLANK:      sw ignored. Frame event = vs_cur (vs_cur is now the new mode) or timeout.
//               Each frame event: fr_cnt++, to_cnt=0. On the event that makes
//               fr_cnt == BLANK_FRAMES: blank <= 0 -> IDLE.
//  mode and blank change on the same clk edge, so no unblanked pixel of a half-switched frame is emitted.
//  After return to IDLE, sw is re-evaluated; a toggle during BLANK triggers a fresh full sequence.
//  busy = (state != IDLE), registered with the state.
//  Latency, stable sw edge -> mode toggle: 2 (sync) + DEBOUNCE_CYCLES + wait for next vs_cur
//   (<= FRAME_TIMEOUT) + 1 cycle.
//  Counters are sized $clog2(max+1) and saturate-free; each is cleared on every state entry.
//  Async rst mid-sequence returns to mode=0 unblanked IDLE immediately. If sw=1, a normal
//   switch follows reset release.
// TESTING  (bench params: DEBOUNCE_CYCLES=8, FRAME_TIMEOUT=64, BLANK_FRAMES=2, VS_POL=0)
//  Reset with sw=0, VS idle high -> mode=0, blank=0, busy=0 held for 200 cycles.
//  sw 0->1 stable; 640 VS low pulse every 40 clk -> mode=1 and blank=1 on the cycle after the
//   first sync edge post-debounce; blank=0 after the 2nd 800 VS edge; busy falls with blank.
//  sw pulses high for 5 cycles, three times -> DEBOUNCE entered/exited, mode stays 0, blank never 1.
//  sw 0->1, then back to 0 during WAIT_FRAME before any VS edge -> IDLE, mode=0, blank never 1.
//  sw 0->1 with both VS held high -> mode toggles 64 cycles after WAIT_FRAME entry; blank
//   clears after 2 further 64-cycle timeouts.
//  Assert rst during BLANK with mode=1 -> mode=0, blank=0, busy=0 asynchronously; with sw=1
//   after release, full switch sequence repeats.

Source files
------------

// File: rtl/vga_mode_sel.sv
// Mode select controller for the dual-resolution VGA mux: debounces the board switch
// and commits a resolution change only on a vertical-sync leading edge, then blanks RGB.
module vga_mode_sel #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FRAME_TIMEOUT   = 2_000_000,
  parameter int BLANK_FRAMES    = 2,
  parameter bit VS_POL          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  input  logic vs_640_480,
  input  logic vs_800_600,
  output logic mode,
  output logic blank,
  output logic busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(FRAME_TIMEOUT + 1);
  localparam int FR_W = $clog2(BLANK_FRAMES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRAME_TIMEOUT - 1);
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLANK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_FRAME, BLANK} state_t;

  state_t          state;
  logic [DB_W-1:0] db_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [FR_W-1:0] fr_cnt;

  logic [1:0] sw_sync;
  logic [1:0] vs640_sync;
  logic [1:0] vs800_sync;
  logic       vs640_d;
  logic       vs800_d;

  logic sw_s;
  logic vs640_s;
  logic vs800_s;
  logic vs640_edge;
  logic vs800_edge;
  logic vs_cur;
  logic frame_evt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of its neighbours and the synchroniser chain shifts by one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync    <= '0;
      vs640_sync <= '0;
      vs800_sync <= '0;
      vs640_d    <= 1'b0;
      vs800_d    <= 1'b0;
    end else begin
      sw_sync    <= {sw_sync[0], sw};
      vs640_sync <= {vs640_sync[0], vs_640_480};
      vs800_sync <= {vs800_sync[0], vs_800_600};
      vs640_d    <= vs640_sync[1];
      vs800_d    <= vs800_sync[1];
    end
  end

  assign sw_s    = sw_sync[1];
  assign vs640_s = vs640_sync[1];
  assign vs800_s = vs800_sync[1];

  // Leading edge = transition into the asserted level; reset value of the delayed
  // flop reads as "asserted" for active-low sync, so release never fakes an edge.
  assign vs640_edge = (vs640_s == VS_POL) && (vs640_d != VS_POL);
  assign vs800_edge = (vs800_s == VS_POL) && (vs800_d != VS_POL);
  assign vs_cur     = mode ? vs800_edge : vs640_edge;
  assign frame_evt  = vs_cur || (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode   <= 1'b0;
      blank  <= 1'b0;
      busy   <= 1'b0;
      db_cnt <= '0;
      to_cnt <= '0;
      fr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sw_s != mode) begin
            state  <= DEBOUNCE;
            busy   <= 1'b1;
            db_cnt <= '0;
          end
        end

        DEBOUNCE: begin
          if (sw_s == mode) begin
            state  <= IDLE;
            busy   <= 1'b0;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= WAIT_FRAME;
            to_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end

        WAIT_FRAME: begin
          // A switch that returns to the current mode wins over a same-cycle edge.
          if (sw_s == mode) begin
            state  <= IDLE;
            busy   <= 1'b0;
            to_cnt <= '0;
          end else if (frame_evt) begin
            state  <= BLANK;
            mode   <= ~mode;
            blank  <= 1'b1;
            fr_cnt <= '0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        BLANK: begin
          if (frame_evt) begin
            to_cnt <= '0;
            if (fr_cnt == FR_LAST) begin
              state  <= IDLE;
              blank  <= 1'b0;
              busy   <= 1'b0;
              fr_cnt <= '0;
            end else begin
              fr_cnt <= fr_cnt + FR_W'(1);
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          blank <= 1'b0;
        end
      endcase
    end
  end

endmodule
